// File: rtl/uart_receiver.sv
// Oversampling UART receive path: 2-flop rx synchronizer, start-bit validation,
// mid-bit sampling and stop check. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 CLKIN,
  input  logic                 RESET,
  input  logic                 clock_enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 framing_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  // state    | meaning
  // S_IDLE   | line idle; waiting for a high->low transition on a tick
  // S_START  | inside start bit; re-check line at its midpoint
  // S_DATA   | sampling payload bits mid-bit, LSB first
  // S_PARITY | sampling the even-parity bit (parity build only)
  // S_STOP   | sampling the stop bit; emit valid or an error pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   armed_q, armed_d;
  logic                   rx_s;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d;
  logic                   par_bad_q, par_bad_d;
`endif

  // Synchronizer runs every CLKIN so the line is never sampled metastable.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Pulses default low every CLKIN so they stay one cycle wide whatever the tick rate.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    armed_d   = armed_q;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    if (clock_enable) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          tick_d = '0;
          // armed_q remembers a high sample, so a stuck-low line never starts a frame
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            armed_d = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              bit_d   = '0;
            end
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_q == TICK_LAST) begin
            par_bad_d = (^shift_q) ^ rx_s;
            state_d   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            state_d = S_IDLE;
            armed_d = rx_s;
            if (!rx_s) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven bit by bit on rx and
// outputs are sampled on the falling edge of CLKIN.
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // ticks from the start-edge tick to the stop sample
  localparam int STOP_TICK = 16 * (NB - 1) + 8;
  // rx falls before edge 1; edge 2 fills the synchronizer; edge 3 is the start-edge tick
  localparam int VCYC = STOP_TICK + 3;

  logic       CLKIN, RESET, clock_enable, rx;
  logic [7:0] data;
  logic       valid, framing_error, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int checks, errors;
  int cyc, vcount, vcyc, fcount, fcyc, pcount, both, busy_cnt;
  int ce_div, ce_ph;
  logic [7:0]  vdata;
  logic [10:0] fr;

  uart_receiver dut (
    .CLKIN        (CLKIN),
    .RESET        (RESET),
    .clock_enable (clock_enable),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .framing_error(framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error (parity_error),
`endif
    .busy         (busy)
  );

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    cyc = 0; vcount = 0; vcyc = 0; fcount = 0; fcyc = 0;
    pcount = 0; both = 0; busy_cnt = 0; vdata = '0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLKIN);
      @(negedge CLKIN);
      cyc++;
      if (valid) begin vcount++; vcyc = cyc; vdata = data; end
      if (framing_error) begin fcount++; fcyc = cyc; end
      if (valid && framing_error) both++;
      if (busy) busy_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_error) pcount++;
`endif
      ce_ph = (ce_ph + 1 == ce_div) ? 0 : ce_ph + 1;
      clock_enable = (ce_ph == 0);
    end
  endtask

  task automatic send(input logic [10:0] bits);
    clear();
    for (int b = 0; b < NB; b++) begin
      rx = bits[b];
      step(16 * ce_div);
    end
  endtask

  // bit 0 is the start bit; correct even parity in the parity build
  function automatic logic [10:0] mk(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {stop, ^d, d, 1'b0};
`else
    return {1'b0, stop, d, 1'b0};
`endif
  endfunction

  initial begin
    checks = 0; errors = 0;
    ce_div = 1; ce_ph = 0;
    RESET = 1'b1; rx = 1'b1; clock_enable = 1'b1;
    clear();
    repeat (3) @(negedge CLKIN);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", framing_error, 1'b0);
    check("rst_busy", busy, 1'b0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr", parity_error, 1'b0);
`endif
    RESET = 1'b0;
    step(20);

    // single frame, exact latency and busy window
    send(mk(8'h55, 1'b1));
    check("t1_vcount", vcount, 1);
    check("t1_vcyc", vcyc, VCYC);
    check("t1_vdata", vdata, 8'h55);
    check("t1_data_held", data, 8'h55);
    check("t1_ferr", fcount, 0);
    check("t1_both", both, 0);
    check("t1_busy_cycles", busy_cnt, STOP_TICK);
    check("t1_perr", pcount, 0);

    // back-to-back frames with no idle gap
    send(mk(8'hA3, 1'b1));
    check("t2a_vcount", vcount, 1);
    check("t2a_vdata", vdata, 8'hA3);
    check("t2a_vcyc", vcyc, VCYC);
    send(mk(8'h00, 1'b1));
    check("t2b_vcount", vcount, 1);
    check("t2b_vdata", vdata, 8'h00);
    check("t2b_vcyc", vcyc, VCYC);
    step(10);

    // 4-tick low glitch: start rejected at mid start bit
    clear();
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(40);
    check("t3_vcount", vcount, 0);
    check("t3_ferr", fcount, 0);
    check("t3_busy_cycles", busy_cnt, 8);
    check("t3_data", data, 8'h00);

    // bad stop bit, then stuck-low line
    send(mk(8'h3C, 1'b0));
    rx = 1'b0;
    step(40);
    check("t4_fcount", fcount, 1);
    check("t4_fcyc", fcyc, VCYC);
    check("t4_vcount", vcount, 0);
    check("t4_data_kept", data, 8'h00);
    check("t4_busy_cycles", busy_cnt, STOP_TICK);
    rx = 1'b1;
    step(20);
    send(mk(8'h5A, 1'b1));
    check("t4_rearm_vcount", vcount, 1);
    check("t4_rearm_vdata", vdata, 8'h5A);

    // reset mid-frame during bit 4 of 0xFF
    clear();
    fr = mk(8'hFF, 1'b1);
    for (int b = 0; b < 5; b++) begin
      rx = fr[b];
      step(16);
    end
    rx = fr[5];
    step(8);
    check("t5_busy_before", busy, 1'b1);
    RESET = 1'b1;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_data", data, 8'h00);
    check("t5_valid", valid, 1'b0);
    check("t5_ferr", framing_error, 1'b0);
    step(2);
    RESET = 1'b0;
    rx = 1'b1;
    step(30);
    check("t5_no_valid", vcount, 0);
    check("t5_no_ferr", fcount, 0);
    send(mk(8'h81, 1'b1));
    check("t5_vcount", vcount, 1);
    check("t5_vdata", vdata, 8'h81);
    check("t5_vcyc", vcyc, VCYC);

    // clock_enable every 3rd CLKIN
    ce_div = 3; ce_ph = 0; clock_enable = 1'b1;
    step(10);
    send(mk(8'hC6, 1'b1));
    check("t6_vcount", vcount, 1);
    check("t6_vdata", vdata, 8'hC6);
    check("t6_ferr", fcount, 0);
    check("t6_busy_cycles", busy_cnt, 3 * STOP_TICK);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    send({1'b1, 1'b0, 8'h07, 1'b0});
    check("t7_slow_bad_perr", pcount, 1);
    check("t7_slow_bad_vcount", vcount, 0);
    check("t7_slow_bad_data", data, 8'hC6);
    send({1'b1, 1'b1, 8'h07, 1'b0});
    check("t7_slow_good_perr", pcount, 0);
    check("t7_slow_good_vcount", vcount, 1);
    check("t7_slow_good_vdata", vdata, 8'h07);
    ce_div = 1; ce_ph = 0; clock_enable = 1'b1;
    step(10);
    send({1'b1, 1'b0, 8'h07, 1'b0});
    check("t7_bad_perr", pcount, 1);
    check("t7_bad_vcount", vcount, 0);
    check("t7_bad_ferr", fcount, 0);
    send({1'b1, 1'b1, 8'h07, 1'b0});
    check("t7_good_vcount", vcount, 1);
    check("t7_good_vdata", vdata, 8'h07);
    check("t7_good_vcyc", vcyc, VCYC);
    // bad parity and bad stop together: framing error only
    send({1'b0, 1'b0, 8'h07, 1'b0});
    check("t7_both_ferr", fcount, 1);
    check("t7_both_perr", pcount, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
